// File: rtl/intra_nbr_avail.sv
// Intra-prediction neighbour availability: two-stage pipeline producing the top-left flag and
// 4-sample unit counts for L/A/AR/BL. Optional macro INTRA_NBR_TILE_EN enables the tile-membership test.
module intra_nbr_avail #(
    parameter int unsigned PIC_W_BITS  = 13,
    parameter int unsigned PIC_H_BITS  = 12,
    parameter int unsigned CTU_BITS    = 9,
    parameter int unsigned TB_CNT_BITS = 16
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIC_W_BITS-1:0]  x_tb,
    input  logic [PIC_H_BITS-1:0]  y_tb,
    input  logic [2:0]             log2_tb,
    input  logic [2:0]             log2_ctb,
    input  logic [PIC_W_BITS-1:0]  pic_w,
    input  logic [PIC_H_BITS-1:0]  pic_h,
    input  logic [CTU_BITS-1:0]    slice_x,
    input  logic [CTU_BITS-1:0]    slice_y,
    input  logic [CTU_BITS-1:0]    tile_x0,
    input  logic [CTU_BITS-1:0]    tile_y0,
    input  logic [CTU_BITS-1:0]    tile_x1,
    input  logic [CTU_BITS-1:0]    tile_y1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   avail_tl,
    output logic [3:0]             cnt_left,
    output logic [3:0]             cnt_above,
    output logic [3:0]             cnt_ar,
    output logic [3:0]             cnt_bl,
    output logic [TB_CNT_BITS-1:0] tb_count
);

    localparam int unsigned XW = PIC_W_BITS + 1;
    localparam int unsigned YW = PIC_H_BITS + 1;
    localparam int unsigned ZW = 8;
    // Point index: 0 current, 1 TL, 2 L, 3 A, 4 AR, 5 BL
    localparam int unsigned NP = 6;

    // N lies in a CTB at or after the slice start and is decoded before the current unit
    function automatic logic order_ok(input logic [CTU_BITS-1:0] nx, input logic [CTU_BITS-1:0] ny,
                                      input logic [CTU_BITS-1:0] cx, input logic [CTU_BITS-1:0] cy,
                                      input logic [CTU_BITS-1:0] sx, input logic [CTU_BITS-1:0] sy,
                                      input logic [ZW-1:0] nz, input logic [ZW-1:0] cz);
        logic after_slice;
        logic before_cur;
        after_slice = (ny > sy) || ((ny == sy) && (nx >= sx));
        before_cur  = (ny < cy) || ((ny == cy) && ((nx < cx) || ((nx == cx) && (nz < cz))));
        return after_slice && before_cur;
    endfunction

    logic s1_valid_q;
    logic out_valid_q;
    logic adv2;
    logic accept;

    assign adv2     = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv2;
    assign accept   = in_valid && in_ready;

    // Stage 1 combinational: neighbour positions, CTB coordinates and z-scan indices
    logic [XW-1:0]                   xw, ntb_x, mask_x, ar_rem_d;
    logic [YW-1:0]                   yw, ntb_y, mask_y, bl_rem_d;
    logic [NP-1:0][XW-1:0]           xs;
    logic [NP-1:0][YW-1:0]           ys;
    logic [NP-1:0][CTU_BITS-1:0]     ctbx_d, ctby_d;
    logic [NP-1:0][ZW-1:0]           z_d;
    logic [NP-1:1]                   inpic_d;
    logic [3:0]                      ux, uy, nq_d;

    always_comb begin
        xw     = XW'(x_tb);
        yw     = YW'(y_tb);
        ntb_x  = XW'(1) << log2_tb;
        ntb_y  = YW'(1) << log2_tb;
        mask_x = (XW'(1) << log2_ctb) - XW'(1);
        mask_y = (YW'(1) << log2_ctb) - YW'(1);
        ux     = '0;
        uy     = '0;
        ctbx_d = '0;
        ctby_d = '0;
        z_d    = '0;
        inpic_d = '0;
        xs[0] = xw;            ys[0] = yw;
        xs[1] = xw - XW'(1);   ys[1] = yw - YW'(1);
        xs[2] = xw - XW'(1);   ys[2] = yw;
        xs[3] = xw;            ys[3] = yw - YW'(1);
        xs[4] = xw + ntb_x;    ys[4] = yw - YW'(1);
        xs[5] = xw - XW'(1);   ys[5] = yw + ntb_y;
        for (int i = 0; i < NP; i++) begin
            ctbx_d[i] = CTU_BITS'(xs[i] >> log2_ctb);
            ctby_d[i] = CTU_BITS'(ys[i] >> log2_ctb);
            ux = 4'((xs[i] & mask_x) >> 2);
            uy = 4'((ys[i] & mask_y) >> 2);
            z_d[i] = {uy[3], ux[3], uy[2], ux[2], uy[1], ux[1], uy[0], ux[0]};
        end
        // Negative coordinates wrap to huge unsigned values and fail the bound test
        for (int i = 1; i < NP; i++) begin
            inpic_d[i] = (xs[i] < XW'(pic_w)) && (ys[i] < YW'(pic_h));
        end
        nq_d     = 4'(ntb_x >> 2);
        ar_rem_d = (XW'(pic_w) - (xw + ntb_x)) >> 2;
        bl_rem_d = (YW'(pic_h) - (yw + ntb_y)) >> 2;
    end

    logic [NP-1:0][CTU_BITS-1:0] ctbx_q, ctby_q;
    logic [NP-1:0][ZW-1:0]       z_q;
    logic [NP-1:1]               inpic_q;
    logic [3:0]                  nq_q;
    logic [XW-1:0]               ar_rem_q;
    logic [YW-1:0]               bl_rem_q;
    logic [CTU_BITS-1:0]         slx_q, sly_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid_q <= 1'b0;
            ctbx_q     <= '0;
            ctby_q     <= '0;
            z_q        <= '0;
            inpic_q    <= '0;
            nq_q       <= '0;
            ar_rem_q   <= '0;
            bl_rem_q   <= '0;
            slx_q      <= '0;
            sly_q      <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                ctbx_q   <= ctbx_d;
                ctby_q   <= ctby_d;
                z_q      <= z_d;
                inpic_q  <= inpic_d;
                nq_q     <= nq_d;
                ar_rem_q <= ar_rem_d;
                bl_rem_q <= bl_rem_d;
                slx_q    <= slice_x;
                sly_q    <= slice_y;
            end
        end
    end

    logic [NP-1:1] in_tile;

`ifdef INTRA_NBR_TILE_EN
    logic [CTU_BITS-1:0] tx0_q, ty0_q, tx1_q, ty1_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tx0_q <= '0;
            ty0_q <= '0;
            tx1_q <= '0;
            ty1_q <= '0;
        end else if (accept) begin
            tx0_q <= tile_x0;
            ty0_q <= tile_y0;
            tx1_q <= tile_x1;
            ty1_q <= tile_y1;
        end
    end

    always_comb begin
        in_tile = '0;
        for (int i = 1; i < NP; i++) begin
            in_tile[i] = (ctbx_q[i] >= tx0_q) && (ctbx_q[i] <= tx1_q) &&
                         (ctby_q[i] >= ty0_q) && (ctby_q[i] <= ty1_q);
        end
    end
`else
    logic unused_tile;
    assign unused_tile = ^{tile_x0, tile_y0, tile_x1, tile_y1, accept};
    assign in_tile     = '1;
`endif

    // Stage 2 combinational: availability and clipped unit counts
    logic [NP-1:1] avail_ok;
    logic [3:0]    cnt_left_d, cnt_above_d, cnt_ar_d, cnt_bl_d;

    always_comb begin
        avail_ok = '0;
        for (int i = 1; i < NP; i++) begin
            avail_ok[i] = inpic_q[i] && in_tile[i] &&
                          order_ok(ctbx_q[i], ctby_q[i], ctbx_q[0], ctby_q[0],
                                   slx_q, sly_q, z_q[i], z_q[0]);
        end
        cnt_left_d  = avail_ok[2] ? nq_q : 4'd0;
        cnt_above_d = avail_ok[3] ? nq_q : 4'd0;
        cnt_ar_d    = 4'd0;
        cnt_bl_d    = 4'd0;
        if (avail_ok[4]) cnt_ar_d = (ar_rem_q >= XW'(nq_q)) ? nq_q : 4'(ar_rem_q);
        if (avail_ok[5]) cnt_bl_d = (bl_rem_q >= YW'(nq_q)) ? nq_q : 4'(bl_rem_q);
    end

    logic                   avail_tl_q;
    logic [3:0]             cnt_left_q, cnt_above_q, cnt_ar_q, cnt_bl_q;
    logic [TB_CNT_BITS-1:0] tb_count_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid_q <= 1'b0;
            avail_tl_q  <= 1'b0;
            cnt_left_q  <= '0;
            cnt_above_q <= '0;
            cnt_ar_q    <= '0;
            cnt_bl_q    <= '0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                avail_tl_q  <= avail_ok[1];
                cnt_left_q  <= cnt_left_d;
                cnt_above_q <= cnt_above_d;
                cnt_ar_q    <= cnt_ar_d;
                cnt_bl_q    <= cnt_bl_d;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tb_count_q <= '0;
        end else if (accept) begin
            tb_count_q <= tb_count_q + TB_CNT_BITS'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign avail_tl  = avail_tl_q;
    assign cnt_left  = cnt_left_q;
    assign cnt_above = cnt_above_q;
    assign cnt_ar    = cnt_ar_q;
    assign cnt_bl    = cnt_bl_q;
    assign tb_count  = tb_count_q;

endmodule

// File: tb/tb_intra_nbr_avail.sv
// Scoreboard bench for intra_nbr_avail: directed corner cases plus randomized requests
// checked against an integer raster-address reference model.
module tb_intra_nbr_avail;

    typedef struct {
        int x, y, l2tb, l2ctb, pw, ph, sx, sy, tx0, ty0, tx1, ty1;
    } req_t;

    typedef struct {
        int tl, cl, ca, car, cbl;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_valid, in_ready;
    logic [12:0] x_tb, pic_w;
    logic [11:0] y_tb, pic_h;
    logic [2:0]  log2_tb, log2_ctb;
    logic [8:0]  slice_x, slice_y, tile_x0, tile_y0, tile_x1, tile_y1;
    logic        out_valid, out_ready;
    logic        avail_tl;
    logic [3:0]  cnt_left, cnt_above, cnt_ar, cnt_bl;
    logic [15:0] tb_count;

    intra_nbr_avail dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_tb(x_tb), .y_tb(y_tb), .log2_tb(log2_tb), .log2_ctb(log2_ctb),
        .pic_w(pic_w), .pic_h(pic_h), .slice_x(slice_x), .slice_y(slice_y),
        .tile_x0(tile_x0), .tile_y0(tile_y0), .tile_x1(tile_x1), .tile_y1(tile_y1),
        .out_valid(out_valid), .out_ready(out_ready), .avail_tl(avail_tl),
        .cnt_left(cnt_left), .cnt_above(cnt_above), .cnt_ar(cnt_ar), .cnt_bl(cnt_bl),
        .tb_count(tb_count)
    );

    always #5 clk = ~clk;

    int   vecs = 0;
    int   errs = 0;
    int   exp_cnt = 0;
    exp_t sbq[$];
    bit   force_or = 1'b1;
    bit   or_val = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int zord(input int u, input int v);
        int z = 0;
        for (int b = 0; b < 4; b++) begin
            z += ((u >> b) & 1) << (2 * b);
            z += ((v >> b) & 1) << (2 * b + 1);
        end
        return z;
    endfunction

    // Reference: raster CTB address (multiplied out) plus z-order within the CTB
    function automatic bit nbr_avail(input req_t r, input int xn, input int yn);
        int ctb = 1 << r.l2ctb;
        int wc  = (r.pw + ctb - 1) / ctb;
        int cur_addr, n_addr, sl_addr;
        if (xn < 0 || yn < 0 || xn >= r.pw || yn >= r.ph) return 0;
`ifdef INTRA_NBR_TILE_EN
        if (xn / ctb < r.tx0 || xn / ctb > r.tx1 || yn / ctb < r.ty0 || yn / ctb > r.ty1) return 0;
`endif
        cur_addr = (r.y / ctb) * wc + r.x / ctb;
        n_addr   = (yn / ctb) * wc + xn / ctb;
        sl_addr  = r.sy * wc + r.sx;
        if (n_addr < sl_addr) return 0;
        if (n_addr < cur_addr) return 1;
        if (n_addr == cur_addr &&
            zord((xn % ctb) / 4, (yn % ctb) / 4) < zord((r.x % ctb) / 4, (r.y % ctb) / 4)) return 1;
        return 0;
    endfunction

    function automatic exp_t model(input req_t r);
        exp_t e;
        int n = 1 << r.l2tb;
        int q = n / 4;
        int rem;
        e.tl  = int'(nbr_avail(r, r.x - 1, r.y - 1));
        e.cl  = nbr_avail(r, r.x - 1, r.y) ? q : 0;
        e.ca  = nbr_avail(r, r.x, r.y - 1) ? q : 0;
        e.car = 0;
        e.cbl = 0;
        if (nbr_avail(r, r.x + n, r.y - 1)) begin
            rem = (r.pw - (r.x + n)) / 4;
            e.car = (rem < q) ? rem : q;
        end
        if (nbr_avail(r, r.x - 1, r.y + n)) begin
            rem = (r.ph - (r.y + n)) / 4;
            e.cbl = (rem < q) ? rem : q;
        end
        return e;
    endfunction

    function automatic req_t mk(input int x, input int y, input int l2tb, input int pw,
                                input int sx, input int sy, input int tx0);
        req_t r;
        r.x = x; r.y = y; r.l2tb = l2tb; r.l2ctb = 6; r.pw = pw; r.ph = 1080;
        r.sx = sx; r.sy = sy; r.tx0 = tx0; r.ty0 = 0; r.tx1 = 511; r.ty1 = 511;
        return r;
    endfunction

    function automatic exp_t ex(input int tl, input int cl, input int ca, input int car, input int cbl);
        exp_t e;
        e.tl = tl; e.cl = cl; e.ca = ca; e.car = car; e.cbl = cbl;
        return e;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int ctb, wc, cx, cy, n, up;
        r.pw    = 8 * (1 + int'($urandom % 64));
        r.ph    = 8 * (1 + int'($urandom % 64));
        r.l2ctb = 4 + int'($urandom % 3);
        up      = (r.l2ctb < 5) ? r.l2ctb : 5;
        r.l2tb  = 2 + int'($urandom % (up - 1));
        n       = 1 << r.l2tb;
        r.x     = int'($urandom % ((r.pw + n - 1) / n)) * n;
        r.y     = int'($urandom % ((r.ph + n - 1) / n)) * n;
        ctb     = 1 << r.l2ctb;
        wc      = (r.pw + ctb - 1) / ctb;
        cx      = r.x / ctb;
        cy      = r.y / ctb;
        r.sy    = int'($urandom % (cy + 1));
        r.sx    = (r.sy == cy) ? int'($urandom % (cx + 1)) : int'($urandom % wc);
        r.tx0   = int'($urandom % (cx + 1));
        r.ty0   = int'($urandom % (cy + 1));
        r.tx1   = cx + int'($urandom % 3);
        r.ty1   = cy + int'($urandom % 3);
        return r;
    endfunction

    task automatic apply(input req_t r);
        x_tb = 13'(r.x); y_tb = 12'(r.y);
        log2_tb = 3'(r.l2tb); log2_ctb = 3'(r.l2ctb);
        pic_w = 13'(r.pw); pic_h = 12'(r.ph);
        slice_x = 9'(r.sx); slice_y = 9'(r.sy);
        tile_x0 = 9'(r.tx0); tile_y0 = 9'(r.ty0); tile_x1 = 9'(r.tx1); tile_y1 = 9'(r.ty1);
    endtask

    // Present one request; the transfer happens at the next rising edge once in_ready is seen
    task automatic send(input req_t r, input exp_t e);
        int w = 0;
        @(negedge clk);
        apply(r);
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            chk("tb_count", int'(tb_count), exp_cnt % 65536);
            sbq.push_back(e);
            exp_cnt++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = force_or ? or_val : ($urandom % 4 != 0);
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks hold under backpressure
    initial begin
        exp_t e;
        exp_t saved;
        bit   held = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!arst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_tl", int'(avail_tl), saved.tl);
                    chk("hold_left", int'(cnt_left), saved.cl);
                    chk("hold_above", int'(cnt_above), saved.ca);
                    chk("hold_ar", int'(cnt_ar), saved.car);
                    chk("hold_bl", int'(cnt_bl), saved.cbl);
                end
                held = 1'b0;
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_out", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("avail_tl", int'(avail_tl), e.tl);
                        chk("cnt_left", int'(cnt_left), e.cl);
                        chk("cnt_above", int'(cnt_above), e.ca);
                        chk("cnt_ar", int'(cnt_ar), e.car);
                        chk("cnt_bl", int'(cnt_bl), e.cbl);
                    end
                end else if (out_valid) begin
                    held = 1'b1;
                    saved = ex(int'(avail_tl), int'(cnt_left), int'(cnt_above), int'(cnt_ar), int'(cnt_bl));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t r;
        arst_n = 1'b0;
        in_valid = 1'b0;
        apply(mk(0, 0, 3, 1920, 0, 0, 0));
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_tb_count", int'(tb_count), 0);
        chk("rst_avail_tl", int'(avail_tl), 0);
        chk("rst_counts", int'({cnt_left, cnt_above, cnt_ar, cnt_bl}), 0);
        @(negedge clk);
        #3 arst_n = 1'b1;

        // Picture corner with latency check
        send(mk(0, 0, 3, 1920, 0, 0, 0), ex(0, 0, 0, 0, 0));
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("latency_stage1", int'(out_valid), 0);
        @(negedge clk);
        #1 chk("latency_out", int'(out_valid), 1);
        idle();

        send(mk(72, 64, 3, 1920, 0, 0, 0), ex(1, 2, 2, 2, 0));
        send(mk(1904, 128, 4, 1920, 0, 0, 0), ex(1, 4, 4, 0, 0));
        send(mk(1888, 128, 4, 1912, 0, 0, 0), ex(1, 4, 4, 2, 4));
        send(mk(192, 128, 3, 1920, 3, 2, 0), ex(0, 0, 0, 0, 0));
`ifdef INTRA_NBR_TILE_EN
        send(mk(192, 128, 3, 1920, 0, 0, 3), ex(0, 0, 2, 2, 0));
`else
        send(mk(192, 128, 3, 1920, 0, 0, 3), ex(1, 2, 2, 2, 2));
`endif
        idle();
        drain();

        // Reset with two items in flight
        or_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r = rnd_req();
            send(r, model(r));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #3 arst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_tb_count", int'(tb_count), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        sbq.delete();
        exp_cnt = 0;
        @(negedge clk);
        #3 arst_n = 1'b1;

        // Five back-to-back requests against four stalled cycles
        @(posedge clk);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    r = rnd_req();
                    send(r, model(r));
                end
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                chk("bp_accepts_while_stalled", exp_cnt, 2);
                or_val = 1'b1;
            end
        join
        drain();
        chk("bp_tb_count", int'(tb_count), 5);

        // Randomized traffic with random backpressure and gaps
        force_or = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r = rnd_req();
            send(r, model(r));
            if ($urandom % 5 == 0) idle();
        end
        idle();
        force_or = 1'b1;
        or_val = 1'b1;
        drain();
        @(negedge clk);
        #1 chk("final_tb_count", int'(tb_count), exp_cnt % 65536);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
